// File: rtl/data_mem_initiator_if.sv
// Request/response and word-memory bus bundle for the MEM-stage load/store initiator.
interface data_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_read_data;

  // initiator side: takes pipeline requests, drives the memory
  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_err, load_data,
    output mem_address, mem_write_data, mem_ctrl
  );

  // pipeline + memory side
  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_err, load_data,
    input  mem_address, mem_write_data, mem_ctrl
  );
endinterface

// File: rtl/data_mem_initiator.sv
// Byte-addressed load/store initiator for a word-addressed, falling-edge data memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
//
// state  | meaning
// IDLE   | ready for a request, no memory access
// RD     | load read issued; capture and extend read data next edge
// RMW_RD | sub-word store: read of the target word issued
// WR     | write issued (whole word or merged word); respond next edge
// ERR    | rejected request; respond with resp_err next edge
module data_mem_initiator #(
  parameter int ADDR_W = 11
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_initiator_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, ERR} state_t;

  localparam logic [2:0] CTRL_NONE  = 3'b000;
  localparam logic [2:0] CTRL_READ  = 3'b100;
  localparam logic [2:0] CTRL_WRITE = 3'b010;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [1:0]          lane_q;
  logic [31:0]         wdata_q;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [31:0]         wr_word_q, wr_word_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         load_data_q, load_data_d;

  logic                accept;
  logic                req_err;
  logic [4:0]          lane_shift;
  logic [31:0]         rd_shifted;
  logic [31:0]         ext_data;
  logic [31:0]         lane_mask;
  logic [31:0]         merged;

  assign accept = bus.req_valid && (state_q == IDLE);

  // misaligned, illegal size, or address beyond the memory depth
  assign req_err = (bus.req_size == 2'b11)
                || ((bus.req_size == 2'b01) && bus.req_addr[0])
                || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                || (|bus.req_addr[31:ADDR_W+2]);

  assign lane_shift = {lane_q, 3'b000};
  assign rd_shifted = bus.mem_read_data >> lane_shift;

  // lane select and sign/zero extension of the returned word
  always_comb begin
    ext_data = bus.mem_read_data;
    case (size_q)
      2'b00:   ext_data = uns_q ? {24'h0, rd_shifted[7:0]}
                                : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   ext_data = uns_q ? {16'h0, rd_shifted[15:0]}
                                : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: ext_data = bus.mem_read_data;
    endcase
  end

  // insert the low byte/half of the store data into the read word
  always_comb begin
    lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
    merged    = (bus.mem_read_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    ctrl_d       = CTRL_NONE;
    wr_word_d    = wr_word_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    load_data_d  = load_data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            state_d = ERR;
          end else if (!bus.req_write) begin
            state_d = RD;
            ctrl_d  = CTRL_READ;
          end else if (bus.req_size == 2'b10) begin
            state_d   = WR;
            ctrl_d    = CTRL_WRITE;
            wr_word_d = bus.req_wdata;
          end else begin
            state_d = RMW_RD;
            ctrl_d  = CTRL_READ;
          end
        end
      end
      RD: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        load_data_d  = ext_data;
      end
      RMW_RD: begin
        state_d   = WR;
        ctrl_d    = CTRL_WRITE;
        wr_word_d = merged;
      end
      WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        load_data_d  = 32'h0;
      end
      ERR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        load_data_d  = 32'h0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset kills any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ctrl_q       <= CTRL_NONE;
      wr_word_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      wr_word_q    <= wr_word_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      load_data_q  <= load_data_d;
    end
  end

  // request fields captured at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      wdata_q <= 32'h0;
    end else if (accept) begin
      addr_q  <= bus.req_addr[ADDR_W+1:2];
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      lane_q  <= bus.req_addr[1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.load_data      = load_data_q;
  assign bus.mem_address    = {{(32-ADDR_W){1'b0}}, addr_q};
  assign bus.mem_write_data = wr_word_q;
  assign bus.mem_ctrl       = ctrl_q;
endmodule

// File: tb/tb_data_mem_initiator.sv
module tb_data_mem_initiator;
  logic clk;
  logic rst_n;
  data_mem_initiator_if bus ();

  data_mem_initiator #(.ADDR_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // falling-edge word memory
  logic [31:0] mem [0:2047];
  always @(negedge clk) begin
    if (bus.mem_ctrl[1]) mem[bus.mem_address[10:0]] <= bus.mem_write_data;
    if (bus.mem_ctrl[2]) bus.mem_read_data <= mem[bus.mem_address[10:0]];
  end

  int bad_ctrl = 0;
  always @(negedge clk) begin
    if (rst_n && ((bus.mem_ctrl[2] && bus.mem_ctrl[1]) || bus.mem_ctrl[0])) bad_ctrl++;
  end

  int checks = 0;
  int passes = 0;

  logic [2:0]  ctrl_seq [0:8];
  logic [31:0] addr0;
  int          lat;
  logic        r_err;
  logic [31:0] r_ld;
  logic        r_ready;

  // drive one request and follow it to its response
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    logic got;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 9; k++) ctrl_seq[k] = 3'b111;
    ctrl_seq[0] = bus.mem_ctrl;
    addr0 = bus.mem_address;
    lat = 0; got = 1'b0; r_err = 1'bx; r_ld = 'x; r_ready = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      ctrl_seq[lat] = bus.mem_ctrl;
      if (bus.resp_valid) begin
        got = 1'b1; r_err = bus.resp_err; r_ld = bus.load_data; r_ready = bus.req_ready;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within 8 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    #12;
    checks++; if (bus.mem_ctrl !== 3'b000) $display("FAIL rst_ctrl got=%b exp=000", bus.mem_ctrl); else passes++;
    checks++; if (bus.mem_address !== 32'h0) $display("FAIL rst_addr got=%h exp=0", bus.mem_address); else passes++;
    checks++; if (bus.mem_write_data !== 32'h0) $display("FAIL rst_wdata got=%h exp=0", bus.mem_write_data); else passes++;
    checks++; if ({bus.resp_valid, bus.resp_err} !== 2'b00) $display("FAIL rst_resp got=%b exp=00", {bus.resp_valid, bus.resp_err}); else passes++;
    checks++; if (bus.load_data !== 32'h0) $display("FAIL rst_load got=%h exp=0", bus.load_data); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", bus.req_ready); else passes++;
  endtask

  task automatic test_word();
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (ctrl_seq[0] !== 3'b010) $display("FAIL sw_ctrl got=%b exp=010", ctrl_seq[0]); else passes++;
    checks++; if (lat !== 1) $display("FAIL sw_lat got=%0d exp=1", lat); else passes++;
    checks++; if (r_ld !== 32'h0) $display("FAIL sw_load got=%h exp=0", r_ld); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (ctrl_seq[0] !== 3'b100) $display("FAIL lw_ctrl got=%b exp=100", ctrl_seq[0]); else passes++;
    checks++; if (addr0 !== 32'd4) $display("FAIL lw_addr got=%h exp=4", addr0); else passes++;
    checks++; if (lat !== 1) $display("FAIL lw_lat got=%0d exp=1", lat); else passes++;
    checks++; if (ctrl_seq[1] !== 3'b000) $display("FAIL lw_ctrl_end got=%b exp=000", ctrl_seq[1]); else passes++;
    checks++; if (r_ld !== 32'hDEADBEEF) $display("FAIL lw_data got=%h exp=deadbeef", r_ld); else passes++;
    checks++; if (r_err !== 1'b0) $display("FAIL lw_err got=%b exp=0", r_err); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL resp_pulse got=%b exp=0", bus.resp_valid); else passes++;
    checks++; if (bus.load_data !== 32'hDEADBEEF) $display("FAIL load_hold got=%h exp=deadbeef", bus.load_data); else passes++;
  endtask

  task automatic test_byte_loads();
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    exp_s = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    exp_u = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'b00, 1'b0, 32'h20 + i, 32'h0);
      checks++; if (r_ld !== exp_s[i]) $display("FAIL lb_signed lane=%0d got=%h exp=%h", i, r_ld, exp_s[i]); else passes++;
      issue(1'b0, 2'b00, 1'b1, 32'h20 + i, 32'h0);
      checks++; if (r_ld !== exp_u[i]) $display("FAIL lb_unsigned lane=%0d got=%h exp=%h", i, r_ld, exp_u[i]); else passes++;
    end
  endtask

  task automatic test_rmw_byte();
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h123456AA);
    checks++; if ({ctrl_seq[0], ctrl_seq[1], ctrl_seq[2]} !== {3'b100, 3'b010, 3'b000})
      $display("FAIL sb_ctrl_seq got=%b %b %b exp=100 010 000", ctrl_seq[0], ctrl_seq[1], ctrl_seq[2]); else passes++;
    checks++; if (lat !== 2) $display("FAIL sb_lat got=%0d exp=2", lat); else passes++;
    checks++; if (r_ready !== 1'b1) $display("FAIL ready_at_resp got=%b exp=1", r_ready); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    checks++; if (r_ld !== 32'h1122AA44) $display("FAIL sb_readback got=%h exp=1122aa44", r_ld); else passes++;
  endtask

  task automatic test_rmw_half();
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    issue(1'b1, 2'b01, 1'b0, 32'h32, 32'hCAFEBEEF);
    checks++; if (lat !== 2) $display("FAIL sh_lat got=%0d exp=2", lat); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    checks++; if (r_ld !== 32'hBEEF3344) $display("FAIL sh_readback got=%h exp=beef3344", r_ld); else passes++;
    issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    checks++; if (r_ld !== 32'hFFFFBEEF) $display("FAIL lh_signed got=%h exp=ffffbeef", r_ld); else passes++;
    issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
    checks++; if (r_ld !== 32'h00003344) $display("FAIL lh_unsigned got=%h exp=00003344", r_ld); else passes++;
  endtask

  task automatic test_errors();
    issue(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
    checks++; if ({r_err, lat} !== {1'b1, 32'd1}) $display("FAIL err_half err=%b lat=%0d exp err=1 lat=1", r_err, lat); else passes++;
    checks++; if ({ctrl_seq[0], ctrl_seq[1]} !== 6'b0) $display("FAIL err_half_ctrl got=%b %b exp=000 000", ctrl_seq[0], ctrl_seq[1]); else passes++;
    checks++; if (r_ld !== 32'h0) $display("FAIL err_load got=%h exp=0", r_ld); else passes++;
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5);
    issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678);
    checks++; if (r_err !== 1'b1) $display("FAIL err_range got=%b exp=1", r_err); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    checks++; if (r_ld !== 32'hA5A5A5A5) $display("FAIL err_range_mem got=%h exp=a5a5a5a5", r_ld); else passes++;
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    checks++; if (r_err !== 1'b1) $display("FAIL err_size got=%b exp=1", r_err); else passes++;
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h0);
    checks++; if (r_err !== 1'b1) $display("FAIL err_word_align got=%b exp=1", r_err); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if ({r_err, r_ld} !== {1'b0, 32'hDEADBEEF}) $display("FAIL err_clear err=%b data=%h exp err=0 data=deadbeef", r_err, r_ld); else passes++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h11223344);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h51; bus.req_wdata = 32'h00000055;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_ctrl !== 3'b100) $display("FAIL mid_rmw_ctrl got=%b exp=100", bus.mem_ctrl); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_ctrl !== 3'b000) $display("FAIL mid_rst_ctrl got=%b exp=000", bus.mem_ctrl); else passes++;
    @(posedge clk); #3 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL mid_no_resp got=%0d exp=0", pulses); else passes++;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", bus.req_ready); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    checks++; if (r_ld !== 32'h11223344) $display("FAIL mid_readback got=%h exp=11223344", r_ld); else passes++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_loads();
    test_rmw_byte();
    test_rmw_half();
    test_errors();
    test_reset_mid();
    checks++; if (bad_ctrl !== 0) $display("FAIL mem_ctrl_legal got=%0d bad cycles exp=0", bad_ctrl); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_initiator.md
Name: data_mem_initiator

Overview:
- Load/store initiator that drives the word-addressed data memory (memCtrl/address/write_data/read_data interface) on behalf of the pipeline's MEM stage.
- Converts byte-addressed byte/half/word loads and stores into word accesses, with sign/zero extension on loads and read-modify-write for sub-word stores.
- Provides a ready/valid request side and a one-cycle response pulse so the pipeline can stall.
- The memory acts on the falling edge; this block registers its outputs on the rising edge and samples read data on the next rising edge.

Parameters:
- ADDR_W, 11, word-address width; memory depth is 2**ADDR_W words (2048).

Ports:
- clk  in  1  system clock, rising-edge logic
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE state)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low bytes are used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid; request was rejected
- load_data  out  32  extended load result, valid with resp_valid
- mem_address  out  32  word address to memory, zero-extended from ADDR_W bits
- mem_write_data  out  32  word to memory
- mem_ctrl  out  3  [2] read, [1] write, [0] always 0
- mem_read_data  in  32  word returned by memory

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_ctrl=000, mem_address=0, mem_write_data=0.
  - resp_valid=0, resp_err=0, load_data=0.
  - req_ready=1 after reset releases.
- Reset mid-operation:
  - Any in-flight access is abandoned and mem_ctrl is forced to 000 immediately, so no falling-edge write occurs.
  - No resp_valid is produced for the abandoned request.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - req_ready = (state==IDLE); it is combinational from state only.
  - All request fields are captured at acceptance.
- Address decode:
  - Word address = req_addr[ADDR_W+1:2].
  - Byte lane = req_addr[1:0], little-endian: lane 0 = bits 7:0.
- Error conditions (no memory access is issued):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - any req_addr bit above ADDR_W+1 set.
  - On error: the next cycle gives resp_valid=1, resp_err=1, load_data=0, then IDLE.
- States: IDLE, RD, RMW_RD, WR, ERR.
- Load (edge T0 accept):
  - IDLE->RD; mem_ctrl=100, mem_address=word address.
  - Memory reads at the falling edge inside the cycle.
  - At T1: capture mem_read_data, select lane, extend; resp_valid=1; mem_ctrl=000; RD->IDLE.
  - Latency is 1 cycle.
- Word store:
  - T0: IDLE->WR; mem_ctrl=010, mem_write_data=req_wdata.
  - T1: resp_valid=1, mem_ctrl=000, IDLE.
- Byte/half store:
  - T0: IDLE->RMW_RD; mem_ctrl=100.
  - T1: merge the req_wdata low byte/half into the read word at the lane; mem_ctrl=010, mem_write_data=merged; ->WR.
  - T2: resp_valid=1, IDLE.
  - Latency is 2 cycles. Other bytes of the word are unchanged.
- mem_ctrl never has bits [2] and [1] set together; bit [0] is always 0.
- resp_valid is exactly one cycle wide. load_data holds its value until the next response; it is 0 for stores.
- Throughput:
  - At most one request outstanding.
  - A new request can be accepted on the edge after resp_valid is asserted (state is IDLE during the resp_valid cycle).
- req_valid during non-IDLE states is ignored; the request is not captured.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> on the load: mem_address=4, mem_ctrl=100 for 1 cycle; resp_valid one cycle later; load_data=0xDEADBEEF; resp_err=0.
- Word 0x80FF7F01 at 0x20, then load byte signed at 0x20/0x21/0x22/0x23 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Same sequence unsigned -> 0x01, 0x7F, 0xFF, 0x80 zero-extended.
- Word 0x11223344 at 0x30, store byte 0xAA at 0x31, then load word -> mem_ctrl sequence 100, 010, 000; resp_valid 2 cycles after accept; word reads 0x1122AA44.
- Store half 0xBEEF at 0x32 onto 0x11223344, then load half signed at 0x32 -> word 0xBEEF3344; load_data=0xFFFFBEEF.
- Errors:
  - Load half at 0x41 -> resp_valid, resp_err=1 next cycle, mem_ctrl stays 000.
  - Word store at 0x2000 (ADDR_W=11) -> resp_err=1, and memory is unchanged.
  - size=11 -> resp_err=1.
- Assert rst_n=0 during the RMW_RD state of a byte store -> mem_ctrl=000 immediately, no resp_valid, target word is unchanged on readback, req_ready=1 after release.
